// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter between the instruction cache and the data
// cache on one side and a single-ported main memory on the other.
//
// One 128-bit line request (read or write) is accepted at a time, forwarded to
// memory, and completed with a one-cycle done pulse to the requester that was
// served. The data cache wins by default; a starvation counter forces an
// icache grant once the data cache has won STARVE_LIMIT times in a row while
// the icache was waiting.
//
// Optional build macro: MEM_ARBITER_TIMEOUT_EN
//   Adds a WAIT-cycle watchdog and the timeout_err output. When it expires the
//   served port gets done with rdata forced to all ones.
//
// Ports:
//   clk, reset (async, active-low)
//   ic_req/ic_op/ic_addr/ic_wdata  -> icache request (op 1=read, 0=write)
//   ic_done/ic_rdata               <- icache completion pulse and read line
//   dc_*                           same for the data cache
//   mem_enable, mem_op_init, mem_op, mem_address, mem_data_in, mem_op_done
//                                  -> memory command side
//   mem_data_ready, mem_data_out   <- memory completion strobe and read line
//   memory_in_use                  high whenever the arbiter is not idle
//   grant_dc                       current or last owner is the data cache
//   timeout_err                    (macro only) pulses with a timed-out done
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic                  ic_op,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic [LINE_WIDTH-1:0] ic_wdata,
  output logic                  ic_done,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_op,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_done,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_enable,
  output logic                  mem_op_init,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  input  logic                  mem_data_ready,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  output logic                  mem_op_done,
  output logic                  memory_in_use,
  output logic                  grant_dc
`ifdef MEM_ARBITER_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            starve_cnt;
  logic                  owner_dc;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] ic_rdata_q;
  logic [LINE_WIDTH-1:0] dc_rdata_q;
  logic                  win_dc;
  logic                  grant_now;
  logic                  capture;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + 4'd1;
  endfunction

  // Data cache wins unless the icache has already been passed over
  // STARVE_MAX times in a row; with only ic_req pending this is 0.
  assign win_dc    = dc_req & ~(ic_req & (starve_cnt == STARVE_MAX));
  assign grant_now = (state == IDLE) & (ic_req | dc_req);
  // Writes never touch the read-data registers.
  assign capture   = (state == WAIT) & mem_data_ready & op_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [9:0] wait_cnt;
  logic       expired;
  logic       timed_out;

  // The 1023rd WAIT cycle without a response ends the wait.
  assign expired     = (state == WAIT) & ~mem_data_ready & (wait_cnt == 10'd1022);
  assign timeout_err = (state == RESP) & timed_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 10'd1;
      end
      if (grant_now) begin
        timed_out <= 1'b0;
      end else if (expired) begin
        timed_out <= 1'b1;
      end
    end
  end
`endif

  // State register and control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_dc   <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_now) begin
        owner_dc <= win_dc;
        // Only a dcache win over a waiting icache counts towards starvation.
        if (win_dc && ic_req) begin
          starve_cnt <= starve_inc(starve_cnt);
        end else begin
          starve_cnt <= '0;
        end
      end
      if (capture) begin
        if (owner_dc) begin
          dc_rdata_q <= mem_data_out;
        end else begin
          ic_rdata_q <= mem_data_out;
        end
      end
`ifdef MEM_ARBITER_TIMEOUT_EN
      if (expired) begin
        if (owner_dc) begin
          dc_rdata_q <= '1;
        end else begin
          ic_rdata_q <= '1;
        end
      end
`endif
    end
  end

  // Request latch: inputs are sampled only on the grant, so later changes on
  // the cache side cannot disturb the transaction in flight.
  always_ff @(posedge clk) begin
    if (grant_now) begin
      op_q    <= win_dc ? dc_op    : ic_op;
      addr_q  <= win_dc ? dc_addr  : ic_addr;
      wdata_q <= win_dc ? dc_wdata : ic_wdata;
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nxt     = state;
    mem_enable    = 1'b0;
    mem_op_init   = 1'b0;
    mem_op        = 1'b0;
    mem_address   = '0;
    mem_data_in   = '0;
    mem_op_done   = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    memory_in_use = (state != IDLE);
    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_enable  = 1'b1;
        mem_op_init = 1'b1;
        mem_op      = op_q;
        mem_address = addr_q;
        mem_data_in = wdata_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        mem_enable  = 1'b1;
        mem_op      = op_q;
        mem_address = addr_q;
        mem_data_in = wdata_q;
        if (mem_data_ready) begin
          state_nxt = RESP;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (expired) begin
          state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        mem_op_done = 1'b1;
        ic_done     = ~owner_dc;
        dc_done     = owner_dc;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ic_rdata = ic_rdata_q;
  assign dc_rdata = dc_rdata_q;
  assign grant_dc = owner_dc;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed stimulus, a memory responder
// with programmable WAIT length, and a transaction-level model that predicts
// grants, done pulses and read data every cycle.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int LW = 128;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ic_req = 1'b0, ic_op = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [LW-1:0] ic_wdata = '0;
  logic          ic_done;
  logic [LW-1:0] ic_rdata;
  logic          dc_req = 1'b0, dc_op = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic          dc_done;
  logic [LW-1:0] dc_rdata;
  logic          mem_enable, mem_op_init, mem_op, mem_op_done;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic          mem_data_ready = 1'b0;
  logic [LW-1:0] mem_data_out = '0;
  logic          memory_in_use, grant_dc;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic          timeout_err;
`endif

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(rst_n),
    .ic_req(ic_req), .ic_op(ic_op), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
    .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_enable(mem_enable), .mem_op_init(mem_op_init), .mem_op(mem_op),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_ready(mem_data_ready), .mem_data_out(mem_data_out),
    .mem_op_done(mem_op_done), .memory_in_use(memory_in_use), .grant_dc(grant_dc)
`ifdef MEM_ARBITER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Memory responder: mem_delay = number of WAIT cycles before the strobe.
  int            mem_delay = 1;
  int            countdown = 0;
  logic [LW-1:0] next_line = '0;

  always begin
    @(posedge clk);
    #1;
    mem_data_ready = 1'b0;
    mem_data_out   = ~next_line;
    if (!rst_n) begin
      countdown = 0;
    end else if (mem_op_init) begin
      countdown = mem_delay;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        mem_data_ready = 1'b1;
        mem_data_out   = next_line;
      end
    end
  end

  // Transaction model: a grant follows any cycle where the arbiter was free
  // and a request was pending; the response arrives the cycle after a strobe
  // seen while waiting (never in the issue cycle).
  bit            p_in_use, p_busy, p_issue, p_rdy;
  bit            p_ic, p_dc, p_icop, p_dcop;
  logic [AW-1:0] p_icaddr, p_dcaddr;
  logic [LW-1:0] p_icwd, p_dcwd, p_line;
  bit            m_issue, m_resp, m_busy, m_win, m_grant, m_op;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wd, e_ic, e_dc;
  bit            glog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_use", memory_in_use, 0);
      chk("rst_ic_done", ic_done, 0);
      chk("rst_dc_done", dc_done, 0);
      chk("rst_mem_enable", mem_enable, 0);
      chk("rst_op_init", mem_op_init, 0);
      chk("rst_op_done", mem_op_done, 0);
      chk("rst_grant_dc", grant_dc, 0);
      chk("rst_ic_rdata", ic_rdata, 0);
      chk("rst_dc_rdata", dc_rdata, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk("rst_mem_op", mem_op, 0);
      m_starve = 0; m_grant = 0; e_ic = '0; e_dc = '0;
      p_in_use = 0; p_busy = 0; p_issue = 0; p_rdy = 0; p_ic = 0; p_dc = 0;
    end else begin
      m_issue = !p_in_use && (p_ic || p_dc);
      m_resp  = p_busy && !p_issue && p_rdy;
      m_busy  = m_issue || (p_busy && !m_resp);
      if (m_issue) begin
        m_win    = p_dc && !(p_ic && m_starve == SL);
        m_starve = (m_win && p_ic) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        m_grant  = m_win;
        m_op     = m_win ? p_dcop   : p_icop;
        m_addr   = m_win ? p_dcaddr : p_icaddr;
        m_wd     = m_win ? p_dcwd   : p_icwd;
        glog.push_back(m_win);
      end
      if (m_resp && m_op) begin
        if (m_grant) e_dc = p_line;
        else e_ic = p_line;
      end
      chk("op_init", mem_op_init, m_issue);
      chk("mem_enable", mem_enable, m_busy);
      chk("in_use", memory_in_use, m_busy || m_resp);
      chk("op_done", mem_op_done, m_resp);
      chk("ic_done", ic_done, m_resp && !m_grant);
      chk("dc_done", dc_done, m_resp && m_grant);
      chk("grant_dc", grant_dc, m_grant);
      chk("ic_rdata", ic_rdata, e_ic);
      chk("dc_rdata", dc_rdata, e_dc);
      if (m_busy) begin
        chk("mem_op", mem_op, m_op);
        chk("mem_address", mem_address, m_addr);
        chk("mem_data_in", mem_data_in, m_wd);
      end
      p_in_use = m_busy || m_resp; p_busy = m_busy; p_issue = m_issue;
      p_rdy = mem_data_ready; p_line = mem_data_out;
      p_ic = ic_req; p_icop = ic_op; p_icaddr = ic_addr; p_icwd = ic_wdata;
      p_dc = dc_req; p_dcop = dc_op; p_dcaddr = dc_addr; p_dcwd = dc_wdata;
    end
  end

  // Issue n back-to-back requests from one port, holding req until each done.
  // lat = cycles from driving the last request to seeing its done.
  task automatic serve(input bit is_dc, input int n, input bit op, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wd, output int lat);
    bit seen;
    int budget;
    lat = 0;
    for (int k = 0; k < n; k++) begin
      if (is_dc) begin
        dc_req = 1'b1; dc_op = op; dc_addr = addr + AW'(k); dc_wdata = wd;
      end else begin
        ic_req = 1'b1; ic_op = op; ic_addr = addr + AW'(k); ic_wdata = wd;
      end
      seen = 1'b0;
      budget = 0;
      while (!seen && budget < 200) begin
        @(posedge clk);
        #1;
        budget++;
        seen = is_dc ? dc_done : ic_done;
      end
      chk(is_dc ? "dc_done_wait" : "ic_done_wait", seen, 1);
      lat = budget;
    end
    if (is_dc) dc_req = 1'b0;
    else ic_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [LW-1:0] LINE_T2 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [LW-1:0] LINE_T3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LW-1:0] LINE_T4 = 128'hCAFEF00D_11112222_33334444_55556666;

  initial begin
    int l1, l2;
    // 1: reset then idle
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    chk("t1_in_use", memory_in_use, 0);
    chk("t1_grant_dc", grant_dc, 0);
    chk("t1_ic_rdata", ic_rdata, 0);

    // 2: single icache read, 5 WAIT cycles
    glog.delete();
    mem_delay = 5;
    next_line = LINE_T2;
    serve(1'b0, 1, 1'b1, 12'h010, '0, l1);
    chk("t2_latency", l1, 7);
    chk("t2_ic_rdata", ic_rdata, LINE_T2);
    chk("t2_grants", glog.size(), 1);
    chk("t2_model_addr", m_addr, 12'h010);
    idle(2);

    // 3: simultaneous requests, dcache first, icache after one idle cycle
    glog.delete();
    mem_delay = 2;
    next_line = LINE_T3;
    fork
      serve(1'b1, 1, 1'b1, 12'h100, '0, l1);
      serve(1'b0, 1, 1'b1, 12'h200, '0, l2);
    join
    chk("t3_ngrants", glog.size(), 2);
    chk("t3_first_dc", glog[0], 1);
    chk("t3_second_ic", glog[1], 0);
    chk("t3_dc_latency", l1, 4);
    chk("t3_ic_latency", l2, 9);
    chk("t3_ic_rdata", ic_rdata, LINE_T3);
    idle(2);

    // 4: starvation, 4 dcache grants then icache
    glog.delete();
    mem_delay = 1;
    next_line = LINE_T4;
    fork
      serve(1'b1, 5, 1'b1, 12'h300, '0, l1);
      serve(1'b0, 1, 1'b1, 12'h020, '0, l2);
    join
    chk("t4_ngrants", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_grant%0d", i), glog[i], (i == 4) ? 1'b0 : 1'b1);
    end
    chk("t4_ic_rdata", ic_rdata, LINE_T4);
    idle(2);

    // 5: dcache write keeps the previous read line
    glog.delete();
    mem_delay = 3;
    next_line = ~LINE_T4;
    serve(1'b1, 1, 1'b0, 12'hFFF, {16{8'hA5}}, l1);
    chk("t5_latency", l1, 5);
    chk("t5_dc_rdata", dc_rdata, LINE_T4);
    chk("t5_model_wdata", m_wd, {16{8'hA5}});
    idle(2);

    // 6: reset during WAIT, no done afterwards
    mem_delay = 50;
    dc_req = 1'b1; dc_op = 1'b1; dc_addr = 12'h0AB;
    idle(4);
    rst_n = 1'b0;
    dc_req = 1'b0;
    #1;
    chk("t6_in_use", memory_in_use, 0);
    chk("t6_dc_done", dc_done, 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    chk("t6_after_in_use", memory_in_use, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter between the instruction cache and the data cache on one side and the single-ported main memory on the other.
- Accepts one line-sized (128-bit) read or write request at a time and forwards it to memory.
- Waits for completion, then returns the line and a done pulse to the requester that was served.
- Default priority goes to the data cache. A starvation counter guarantees the instruction cache is served.

Parameters:
- ADDR_WIDTH, 12, line address width towards main memory.
- LINE_WIDTH, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive dcache grants allowed while icache waits; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- ic_req  in  1  icache request valid; held high until ic_done.
- ic_op  in  1  icache op, 1=read, 0=write.
- ic_addr  in  ADDR_WIDTH  icache line address.
- ic_wdata  in  LINE_WIDTH  icache write line.
- ic_done  out  1  one-cycle completion pulse to icache.
- ic_rdata  out  LINE_WIDTH  read line to icache; valid while ic_done=1.
- dc_req, dc_op, dc_addr, dc_wdata, dc_done, dc_rdata: same definitions for the data cache.
- mem_enable  out  1  memory access active.
- mem_op_init  out  1  one-cycle start pulse to memory.
- mem_op  out  1  forwarded op.
- mem_address  out  ADDR_WIDTH  forwarded address.
- mem_data_in  out  LINE_WIDTH  forwarded write line.
- mem_data_ready  in  1  memory completion strobe.
- mem_data_out  in  LINE_WIDTH  memory read line; valid with mem_data_ready.
- mem_op_done  out  1  one-cycle acknowledge to memory.
- memory_in_use  out  1  high whenever state != IDLE.
- grant_dc  out  1  current or last owner is dcache.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; starve counter = 0.
  - All outputs 0, including rdata buses and grant_dc.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner. Winner is dcache if dc_req=1, unless ic_req=1 and starve counter == STARVE_LIMIT.
  - If only ic_req=1, the winner is icache.
  - Latch the winner's op, addr and wdata into internal registers. Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_enable=1, mem_op_init=1.
  - mem_op, mem_address and mem_data_in driven from the latched registers. Go to WAIT.
- WAIT:
  - mem_enable=1, mem_op_init=0.
  - Stay until mem_data_ready=1. On that cycle latch mem_data_out into the winner's rdata register. Go to RESP.
  - A mem_data_ready seen in ISSUE is ignored.
- RESP (exactly 1 cycle):
  - Winner's done=1; mem_op_done=1; mem_enable=0. Go to IDLE.
  - rdata holds its value until the next completion to that port.
  - Write ops also pulse done; rdata is unchanged for writes.
- Starve counter, updated at the IDLE->ISSUE transition:
  - dcache wins while ic_req=1: counter+1, saturating at STARVE_LIMIT.
  - icache wins: counter cleared to 0.
  - ic_req=0: counter cleared to 0.
- Request changes mid-operation:
  - Requester inputs are sampled only in IDLE. Changes during ISSUE/WAIT/RESP have no effect on the transaction in flight.
  - A requester dropping req before done is a protocol violation; the transaction still completes and done still pulses.
- Minimum latency from req sampled in IDLE to done is 3 cycles plus the memory wait (IDLE, ISSUE, WAIT >= 1 cycle, then RESP).
- After RESP, the arbiter returns to IDLE for at least 1 cycle before the next grant.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no done pulse is produced. Memory-side state is memory's responsibility.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- When defined:
  - Adds a 10-bit WAIT-cycle counter, cleared on entry to WAIT.
  - If it reaches 1023 without mem_data_ready, go to RESP with the winner's done=1 and rdata forced to all ones.
  - Adds port timeout_err (out, 1), which pulses with that done. mem_op_done still pulses.
- When undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles, release, no requests for 10 cycles -> all outputs 0, memory_in_use=0.
2. Single icache read: ic_req=1, ic_op=1, ic_addr=12'h010; memory returns 128'hDEADBEEF_..._0001 after 5 WAIT cycles.
   - Required: mem_op_init pulses once with mem_address=12'h010.
   - Required: ic_done pulses 1 cycle after mem_data_ready, with ic_rdata equal to the returned data; dc_done stays 0.
3. Simultaneous requests: ic_req and dc_req asserted in the same cycle.
   - dcache is served first, grant_dc=1.
   - icache is served next after one IDLE cycle.
4. Starvation: ic_req held, dc_req re-asserted immediately after each dc_done, STARVE_LIMIT=4 -> exactly 4 dcache grants, then icache; counter returns to 0.
5. dcache write: dc_op=0, dc_addr=12'hFFF, dc_wdata=all 0xA5 bytes.
   - mem_op=0 and mem_data_in matches the written line.
   - dc_done pulses and dc_rdata keeps its previous value.
6. Reset mid-WAIT: assert reset during WAIT -> memory_in_use=0 within the same cycle and no done pulse. With MEM_ARBITER_TIMEOUT_EN, a memory that never responds produces timeout_err and done after 1023 WAIT cycles.
